io_port_ctrl: RTL and testbench

Parametrised I/O controller for the accumulator processor. It buffers switch entries in an input FIFO and serves processor IN requests with a stall/valid handshake. It holds the processor on BRK until a resume press. It drives NUM_OUT display channels, each as sign-magnitude with a negative flag. It sits between the datapath IO signals and the board switches/displays, all clocked by button_clock.

---
 rtl/io_port_ctrl.sv | 121 ++++++++++++
 tb/tb_io_port_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_ctrl.sv
// I/O controller for the accumulator processor: switch-entry FIFO serving IN requests,
// BRK hold until a resume press, and sign-magnitude display channels.
module io_port_ctrl #(
    parameter int DATA_W     = 32,
    parameter int NUM_OUT    = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                      button_clock,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         sw_data,
    input  logic                      sw_valid,
    input  logic                      io_rd,
    input  logic                      io_wr,
    input  logic [CH_W-1:0]           io_ch,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      brk,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_valid,
    output logic                      stall,
    output logic                      ack_toggle,
    output logic [NUM_OUT*DATA_W-1:0] out_mag,
    output logic [NUM_OUT-1:0]        out_neg,
    output logic [NUM_OUT-1:0]        out_ovf,
    output logic [CNT_W-1:0]          fifo_count,
    output logic                      fifo_full,
    output logic                      in_overrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IN  = 2'd1,
        BRK_HOLD = 2'd2
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              fifo_empty;
    logic              pop_en, push_req, push_en, drop, resume;
    logic              wr_neg;
    logic [DATA_W-1:0] wr_mag;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign stall      = (state != IDLE);

    // Pops only happen when a read is being served; WAIT_IN drains the word pushed on the previous edge.
    assign pop_en   = !fifo_empty && ((state == IDLE && io_rd) || state == WAIT_IN);
    assign push_req = sw_valid && (state != BRK_HOLD);
    assign push_en  = push_req && (!fifo_full || pop_en);
    assign drop     = push_req && fifo_full && !pop_en;
    assign resume   = (state == BRK_HOLD) && sw_valid;

    assign wr_neg = wr_data[DATA_W-1];
    assign wr_mag = wr_neg ? (DATA_W'(0) - wr_data) : wr_data;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (io_rd) begin
                    if (fifo_empty) state_next = WAIT_IN;
                end else if (brk) begin
                    state_next = BRK_HOLD;
                end
            end
            WAIT_IN:  if (!fifo_empty) state_next = IDLE;
            BRK_HOLD: if (sw_valid) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge button_clock) begin
        if (push_en) mem[wr_ptr] <= sw_data;
    end

    always_ff @(posedge button_clock) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            ack_toggle <= 1'b0;
            in_overrun <= 1'b0;
            out_mag    <= '0;
            out_neg    <= '0;
            out_ovf    <= '0;
        end else begin
            state    <= state_next;
            rd_valid <= pop_en;
            if (pop_en) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (pop_en || resume) ack_toggle <= ~ack_toggle;
            if (drop) in_overrun <= 1'b1;
            for (int k = 0; k < NUM_OUT; k++) begin
                if (io_wr && int'(io_ch) == k) begin
                    out_mag[k*DATA_W +: DATA_W] <= wr_mag;
                    out_neg[k]                  <= wr_neg;
                    out_ovf[k]                  <= (wr_data == MIN_NEG);
                end
            end
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl: vector table for FIFO/IN/BRK flow, hand sequences for
// display channels and reset during stalled states.
module tb_io_port_ctrl;

    localparam int DATA_W  = 32;
    localparam int NUM_OUT = 3;
    localparam int DEPTH   = 4;

    logic                      button_clock = 1'b0;
    logic                      reset = 1'b0;
    logic [DATA_W-1:0]         sw_data = '0;
    logic                      sw_valid = 1'b0;
    logic                      io_rd = 1'b0;
    logic                      io_wr = 1'b0;
    logic [1:0]                io_ch = '0;
    logic [DATA_W-1:0]         wr_data = '0;
    logic                      brk = 1'b0;
    logic [DATA_W-1:0]         rd_data;
    logic                      rd_valid;
    logic                      stall;
    logic                      ack_toggle;
    logic [NUM_OUT*DATA_W-1:0] out_mag;
    logic [NUM_OUT-1:0]        out_neg;
    logic [NUM_OUT-1:0]        out_ovf;
    logic [2:0]                fifo_count;
    logic                      fifo_full;
    logic                      in_overrun;

    int checks = 0;
    int errors = 0;

    io_port_ctrl #(.DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .FIFO_DEPTH(DEPTH)) dut (
        .button_clock(button_clock), .reset(reset), .sw_data(sw_data), .sw_valid(sw_valid),
        .io_rd(io_rd), .io_wr(io_wr), .io_ch(io_ch), .wr_data(wr_data), .brk(brk),
        .rd_data(rd_data), .rd_valid(rd_valid), .stall(stall), .ack_toggle(ack_toggle),
        .out_mag(out_mag), .out_neg(out_neg), .out_ovf(out_ovf), .fifo_count(fifo_count),
        .fifo_full(fifo_full), .in_overrun(in_overrun)
    );

    always #5 button_clock = ~button_clock;

    typedef struct {
        logic [31:0] sw_data;
        logic        sw_valid;
        logic        io_rd;
        logic        brk;
        logic        exp_rv;
        logic [31:0] exp_rd;
        logic        exp_stall;
        logic        exp_ack;
        logic [2:0]  exp_cnt;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] sd, logic sv, logic rd, logic bk, logic rv,
                                logic [31:0] erd, logic st, logic ack, logic [2:0] cnt, logic ovr);
        vec_t v;
        v.sw_data = sd; v.sw_valid = sv; v.io_rd = rd; v.brk = bk; v.exp_rv = rv;
        v.exp_rd = erd; v.exp_stall = st; v.exp_ack = ack; v.exp_cnt = cnt; v.exp_ovr = ovr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge button_clock);
        #1;
    endtask

    task automatic idle_inputs();
        sw_data = '0; sw_valid = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
        io_ch = '0; wr_data = '0; brk = 1'b0; reset = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " stall"}, 64'(stall), 64'd0);
        check({tag, " rd_valid"}, 64'(rd_valid), 64'd0);
        check({tag, " rd_data"}, 64'(rd_data), 64'd0);
        check({tag, " ack"}, 64'(ack_toggle), 64'd0);
        check({tag, " count"}, 64'(fifo_count), 64'd0);
        check({tag, " overrun"}, 64'(in_overrun), 64'd0);
        check({tag, " mag0"}, 64'(out_mag[31:0]), 64'd0);
        check({tag, " mag1"}, 64'(out_mag[63:32]), 64'd0);
        check({tag, " mag2"}, 64'(out_mag[95:64]), 64'd0);
        check({tag, " neg"}, 64'(out_neg), 64'd0);
        check({tag, " ovf"}, 64'(out_ovf), 64'd0);
    endtask

    initial begin
        // push 5,7 then read both; empty read; fill to overflow; BRK hold and resume
        //                sw     sv  rd  bk  rv  rd_data st ack cnt ovr
        vecs.push_back(mk(32'h5,  1, 0, 0,  0, 32'h0,  0, 0, 1, 0));
        vecs.push_back(mk(32'h7,  1, 0, 0,  0, 32'h0,  0, 0, 2, 0));
        vecs.push_back(mk(32'h0,  0, 1, 0,  1, 32'h5,  0, 1, 1, 0));
        vecs.push_back(mk(32'h0,  0, 1, 0,  1, 32'h7,  0, 0, 0, 0));
        vecs.push_back(mk(32'h0,  0, 0, 0,  0, 32'h7,  0, 0, 0, 0));
        vecs.push_back(mk(32'h0,  0, 1, 0,  0, 32'h7,  1, 0, 0, 0));
        vecs.push_back(mk(32'h0,  0, 1, 0,  0, 32'h7,  1, 0, 0, 0));
        vecs.push_back(mk(32'h2A, 1, 0, 0,  0, 32'h7,  1, 0, 1, 0));
        vecs.push_back(mk(32'h0,  0, 0, 0,  1, 32'h2A, 0, 1, 0, 0));
        vecs.push_back(mk(32'h11, 1, 0, 0,  0, 32'h2A, 0, 1, 1, 0));
        vecs.push_back(mk(32'h12, 1, 0, 0,  0, 32'h2A, 0, 1, 2, 0));
        vecs.push_back(mk(32'h13, 1, 0, 0,  0, 32'h2A, 0, 1, 3, 0));
        vecs.push_back(mk(32'h14, 1, 0, 0,  0, 32'h2A, 0, 1, 4, 0));
        vecs.push_back(mk(32'h15, 1, 0, 0,  0, 32'h2A, 0, 1, 4, 1));
        vecs.push_back(mk(32'h16, 1, 1, 0,  1, 32'h11, 0, 0, 4, 1));
        vecs.push_back(mk(32'h0,  0, 1, 0,  1, 32'h12, 0, 1, 3, 1));
        vecs.push_back(mk(32'h0,  0, 1, 0,  1, 32'h13, 0, 0, 2, 1));
        vecs.push_back(mk(32'h0,  0, 1, 0,  1, 32'h14, 0, 1, 1, 1));
        vecs.push_back(mk(32'h0,  0, 1, 0,  1, 32'h16, 0, 0, 0, 1));
        vecs.push_back(mk(32'h3,  1, 0, 0,  0, 32'h16, 0, 0, 1, 1));
        vecs.push_back(mk(32'h0,  0, 0, 1,  0, 32'h16, 1, 0, 1, 1));
        vecs.push_back(mk(32'h0,  0, 1, 1,  0, 32'h16, 1, 0, 1, 1));
        vecs.push_back(mk(32'h9,  1, 0, 1,  0, 32'h16, 0, 1, 1, 1));
        vecs.push_back(mk(32'h0,  0, 1, 0,  1, 32'h3,  0, 0, 0, 1));
        vecs.push_back(mk(32'h8,  1, 0, 0,  0, 32'h3,  0, 0, 1, 1));
        vecs.push_back(mk(32'h0,  0, 1, 1,  1, 32'h8,  0, 1, 0, 1));
        vecs.push_back(mk(32'h0,  0, 0, 0,  0, 32'h8,  0, 1, 0, 1));

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check_cleared("reset");
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            sw_data = vecs[i].sw_data; sw_valid = vecs[i].sw_valid;
            io_rd = vecs[i].io_rd; brk = vecs[i].brk;
            tick();
            check($sformatf("v%0d rd_valid", i), 64'(rd_valid), 64'(vecs[i].exp_rv));
            check($sformatf("v%0d rd_data", i), 64'(rd_data), 64'(vecs[i].exp_rd));
            check($sformatf("v%0d stall", i), 64'(stall), 64'(vecs[i].exp_stall));
            check($sformatf("v%0d ack", i), 64'(ack_toggle), 64'(vecs[i].exp_ack));
            check($sformatf("v%0d count", i), 64'(fifo_count), 64'(vecs[i].exp_cnt));
            check($sformatf("v%0d full", i), 64'(fifo_full), 64'(vecs[i].exp_cnt == 3'd4));
            check($sformatf("v%0d overrun", i), 64'(in_overrun), 64'(vecs[i].exp_ovr));
        end
        idle_inputs();

        // display channels: negative, most-negative, positive, out-of-range select
        io_wr = 1'b1; io_ch = 2'd0; wr_data = 32'hFFFF_FFF6;
        tick();
        check("ch0 mag neg", 64'(out_mag[31:0]), 64'd10);
        check("ch0 neg", 64'(out_neg), 64'b001);
        check("ch0 ovf", 64'(out_ovf), 64'b000);
        io_ch = 2'd1; wr_data = 32'h8000_0000;
        tick();
        check("ch1 mag min", 64'(out_mag[63:32]), 64'h8000_0000);
        check("ch1 neg", 64'(out_neg), 64'b011);
        check("ch1 ovf", 64'(out_ovf), 64'b010);
        check("ch0 held", 64'(out_mag[31:0]), 64'd10);
        io_ch = 2'd2; wr_data = 32'h0000_1234;
        tick();
        check("ch2 mag pos", 64'(out_mag[95:64]), 64'h1234);
        check("ch2 neg", 64'(out_neg), 64'b011);
        io_ch = 2'd0; wr_data = 32'h7FFF_FFFF;
        tick();
        check("ch0 mag max", 64'(out_mag[31:0]), 64'h7FFF_FFFF);
        check("ch0 neg clr", 64'(out_neg), 64'b010);
        io_ch = 2'd3; wr_data = 32'hFFFF_FFFF;
        tick();
        check("bad ch mag", 64'(out_mag), 64'({32'h1234, 32'h8000_0000, 32'h7FFF_FFFF}));
        check("bad ch neg", 64'(out_neg), 64'b010);
        check("bad ch ovf", 64'(out_ovf), 64'b010);

        // write accepted while stalled in BRK_HOLD
        idle_inputs();
        brk = 1'b1;
        tick();
        check("brk stall", 64'(stall), 64'd1);
        brk = 1'b0; io_wr = 1'b1; io_ch = 2'd2; wr_data = 32'hFFFF_FFFF;
        tick();
        check("wr in brk mag", 64'(out_mag[95:64]), 64'd1);
        check("wr in brk neg", 64'(out_neg), 64'b110);

        // reset while stalled in BRK_HOLD
        idle_inputs();
        reset = 1'b1;
        tick();
        check_cleared("reset brk");
        reset = 1'b0;

        // reset while waiting for an IN abandons the read
        io_rd = 1'b1;
        tick();
        check("wait stall", 64'(stall), 64'd1);
        io_rd = 1'b0; reset = 1'b1;
        tick();
        check_cleared("reset wait");
        reset = 1'b0;
        sw_data = 32'h4; sw_valid = 1'b1;
        tick();
        check("post rst push count", 64'(fifo_count), 64'd1);
        check("post rst push rv", 64'(rd_valid), 64'd0);
        sw_valid = 1'b0;
        tick();
        check("post rst idle rv", 64'(rd_valid), 64'd0);
        check("post rst idle count", 64'(fifo_count), 64'd1);
        check("post rst idle ack", 64'(ack_toggle), 64'd0);
        io_rd = 1'b1;
        tick();
        check("post rst read rv", 64'(rd_valid), 64'd1);
        check("post rst read data", 64'(rd_data), 64'h4);
        check("post rst read ack", 64'(ack_toggle), 64'd1);
        io_rd = 1'b0;
        tick();
        check("post rst rv drop", 64'(rd_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
